// File: rtl/parallel_to_serial_params_pkg.sv
// Shared parameters and types for the parallel-to-serial transmit datapath.
// Contents:
//   BAUD_*          cfg_baud encodings (00/01/10/11 = 9600/19200/38400/115200)
//   PARITY_*        cfg_parity_en encodings
//   MIN/MAX_NUM_PACKETS  legal burst length range
//   DATA_WIDTH, DIV_W    data bits per packet, baud divisor counter width
//   line_sel_t      line mux select driven to the external line mux
//   tx_state_t      transmit sequencer states
//   baud_div()      rounded clock-per-bit divisor for a baud selection
package parallel_to_serial_params_pkg;

  localparam logic [1:0] BAUD_9600   = 2'b00;
  localparam logic [1:0] BAUD_19200  = 2'b01;
  localparam logic [1:0] BAUD_38400  = 2'b10;
  localparam logic [1:0] BAUD_115200 = 2'b11;

  localparam logic PARITY_DISABLED = 1'b0;
  localparam logic PARITY_ENABLED  = 1'b1;

  localparam logic [9:0] MIN_NUM_PACKETS = 10'd1;
  localparam logic [9:0] MAX_NUM_PACKETS = 10'd1000;

  localparam int DATA_WIDTH = 8;
  localparam int DIV_W      = 13;

  typedef enum logic [2:0] {
    LINE_IDLE   = 3'd0,
    LINE_START  = 3'd1,
    LINE_DATA   = 3'd2,
    LINE_PARITY = 3'd3,
    LINE_STOP   = 3'd4
  } line_sel_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    PARITY    = 3'd4,
    STOP      = 3'd5
  } tx_state_t;

  // round(clk_hz / baud); clk_hz is a elaboration-time constant, so this
  // reduces to a four-way mux of constants.
  function automatic logic [DIV_W-1:0] baud_div(bit [1:0] sel, int clk_hz);
    int rate;
    case (sel)
      BAUD_9600:  rate = 9600;
      BAUD_19200: rate = 19200;
      BAUD_38400: rate = 38400;
      default:    rate = 115200;
    endcase
    return DIV_W'((clk_hz + rate / 2) / rate);
  endfunction

endpackage

// File: rtl/piso_tx_controller_if.sv
// Upstream byte stream into the transmit controller.
// Ports (signals):
//   in_valid  source -> controller  byte valid
//   in_data   source -> controller  byte
//   in_ready  controller -> source  controller accepts byte
// Handshake: a byte transfers on a rising clk edge where in_valid and
// in_ready are both high. The source holds in_data stable while in_valid is
// high and not yet accepted; in_ready never depends combinationally on
// in_valid.
interface piso_tx_controller_if #(
  parameter int DATA_WIDTH = parallel_to_serial_params_pkg::DATA_WIDTH
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/piso_baud_gen.sv
// Bit-time generator: down-counter that reloads div-1 on restart or when it
// reaches zero; tick is high in the cycle the count is zero, so every bit
// time spans exactly div cycles after a restart.
// Ports: clk, rst (async, active high), restart (reload now), div (clocks
// per bit), tick (last cycle of the current bit time).
module piso_baud_gen
  import parallel_to_serial_params_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= div - DIV_W'(1);
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/piso_tx_controller.sv
// Sequencer for the PISO transmit datapath. Accepts a burst command, pulls
// bytes from the upstream stream and drives load/shift/line-select controls
// to an external shifter and line mux, one frame per byte.
// Ports:
//   clk, rst              clock, async active-high reset
//   cfg_baud/parity_en/num_pkts  burst configuration, latched on start
//   start                 one-cycle burst request
//   up                    upstream byte stream (slave side)
//   sh_load, sh_data      shifter load pulse and byte
//   sh_shift              shifter advance pulse
//   line_sel              line mux select
//   parity_bit            even parity of the current byte
//   busy, done, cfg_err   burst status / completion / rejected start
//   pkt_cnt               packets fully sent in the current burst
//   state_dbg             current sequencer state
module piso_tx_controller #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DATA_WIDTH  = parallel_to_serial_params_pkg::DATA_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [1:0]                              cfg_baud,
  input  logic                                    cfg_parity_en,
  input  logic [9:0]                              cfg_num_pkts,
  input  logic                                    start,
  piso_tx_controller_if.slave                     up,
  output logic                                    sh_load,
  output logic [DATA_WIDTH-1:0]                   sh_data,
  output logic                                    sh_shift,
  output parallel_to_serial_params_pkg::line_sel_t line_sel,
  output logic                                    parity_bit,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    cfg_err,
  output logic [9:0]                              pkt_cnt,
  output parallel_to_serial_params_pkg::tx_state_t state_dbg
);
  import parallel_to_serial_params_pkg::*;

  localparam int              IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_t        state;
  logic [DIV_W-1:0] div_q;
  logic             par_en_q;
  logic [9:0]       num_pkts_q;
  logic [IDX_W-1:0] bit_idx;
  logic             in_ready_q;
  logic             tick;
  logic             handshake;
  logic             cfg_ok;
  logic [9:0]       pkt_cnt_next;

  assign handshake    = (state == WAIT_DATA) && up.in_valid && in_ready_q;
  assign cfg_ok       = (cfg_num_pkts >= MIN_NUM_PACKETS) && (cfg_num_pkts <= MAX_NUM_PACKETS);
  assign pkt_cnt_next = pkt_cnt + 10'd1;
  assign up.in_ready  = in_ready_q;
  assign state_dbg    = state;

  // Restarting on the handshake aligns the first bit time with sh_load.
  piso_baud_gen u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .restart (handshake),
    .div     (div_q),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_q      <= baud_div(BAUD_9600, CLK_FREQ_HZ);
      par_en_q   <= PARITY_DISABLED;
      num_pkts_q <= '0;
      bit_idx    <= '0;
      in_ready_q <= 1'b0;
      sh_load    <= 1'b0;
      sh_data    <= '0;
      sh_shift   <= 1'b0;
      line_sel   <= LINE_IDLE;
      parity_bit <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      sh_load  <= 1'b0;
      sh_shift <= 1'b0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              div_q      <= baud_div(cfg_baud, CLK_FREQ_HZ);
              par_en_q   <= cfg_parity_en;
              num_pkts_q <= cfg_num_pkts;
              pkt_cnt    <= '0;
              busy       <= 1'b1;
              in_ready_q <= 1'b1;
              state      <= WAIT_DATA;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end

        WAIT_DATA: begin
          if (handshake) begin
            in_ready_q <= 1'b0;
            sh_load    <= 1'b1;
            sh_data    <= up.in_data;
            parity_bit <= ^up.in_data;
            line_sel   <= LINE_START;
            state      <= START;
          end
        end

        START: begin
          if (tick) begin
            bit_idx  <= '0;
            line_sel <= LINE_DATA;
            state    <= DATA;
          end
        end

        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_IDX) begin
              line_sel <= par_en_q ? LINE_PARITY : LINE_STOP;
              state    <= par_en_q ? PARITY : STOP;
            end else begin
              // Bit 0 is presented at load; each earlier-bit tick advances.
              sh_shift <= 1'b1;
              bit_idx  <= bit_idx + IDX_W'(1);
            end
          end
        end

        PARITY: begin
          if (tick) begin
            line_sel <= LINE_STOP;
            state    <= STOP;
          end
        end

        STOP: begin
          if (tick) begin
            pkt_cnt  <= pkt_cnt_next;
            line_sel <= LINE_IDLE;
            if (pkt_cnt_next == num_pkts_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              in_ready_q <= 1'b1;
              state      <= WAIT_DATA;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/piso_tx_controller.md
Name: piso_tx_controller

Overview:
- Sequencer for the parallel-to-serial (PISO) transmit datapath.
- Accepts a packet-burst command with baud and parity configuration, and pulls parallel bytes from an upstream valid/ready source.
- Generates the bit-time tick and drives load, shift and line-select controls to the external shifter/line mux.
- Counts packets and signals burst completion.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency; sets baud divisors.
- DATA_WIDTH, 8, data bits per packet.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- cfg_baud  in  2  BAUD_9600/19200/38400/115200 encoding (00/01/10/11).
- cfg_parity_en  in  1  PARITY_DISABLED/PARITY_ENABLED.
- cfg_num_pkts  in  10  packets in burst; legal range MIN_NUM_PACKETS..MAX_NUM_PACKETS (1..1000).
- start  in  1  one-cycle burst request.
- in_valid  in  1  upstream byte valid.
- in_data  in  DATA_WIDTH  upstream byte.
- in_ready  out  1  controller accepts byte.
- sh_load  out  1  one-cycle pulse: shifter loads sh_data.
- sh_data  out  DATA_WIDTH  byte to load (registered copy of in_data).
- sh_shift  out  1  one-cycle pulse: shifter advances one data bit.
- line_sel  out  3  line mux select: IDLE(1), START(0), DATA, PARITY, STOP(1).
- parity_bit  out  1  even parity of current byte.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- pkt_cnt  out  10  packets fully transmitted in current burst.

Behaviour:
- Reset values: all outputs 0, except line_sel=IDLE. Reset is asynchronous; asserting it mid-frame aborts immediately and returns to IDLE.
- Divisors, round(CLK_FREQ_HZ/baud), at 50 MHz: 5208, 2604, 1302, 434. One bit time = DIV clocks. Divisor counter is 13 bits.
- start in IDLE:
  - Legal cfg_num_pkts: latch cfg_baud, cfg_parity_en, cfg_num_pkts; clear pkt_cnt; busy=1; go to WAIT_DATA.
  - cfg_num_pkts = 0 or > 1000: pulse cfg_err next cycle; remain IDLE.
- start while busy is ignored. cfg_* changes during a burst are ignored.
- WAIT_DATA: in_ready=1, line_sel=IDLE. A handshake in cycle N (in_valid&in_ready) causes:
  - cycle N+1: sh_load=1, sh_data=byte, parity_bit=^byte, line_sel=START.
  - baud counter restarts at DIV-1 in N+1.
  - in_ready=0 from N+1 until the next WAIT_DATA.
- Baud tick: fires when the counter reaches 0, then reloads DIV-1. Each state lasts exactly DIV cycles.
- START (1 bit time) -> DATA.
- DATA: DATA_WIDTH bit times, bit_idx 0..DATA_WIDTH-1.
  - sh_shift pulses on the tick ending bits 0..DATA_WIDTH-2 (DATA_WIDTH-1 pulses per frame).
  - Last tick goes to PARITY if parity is enabled, else STOP.
- PARITY (1 bit time) -> STOP.
- STOP (1 bit time). On its tick pkt_cnt increments.
  - If the new pkt_cnt == num_pkts: go to IDLE, done pulses 1 cycle, busy=0 in the same cycle.
  - Otherwise go to WAIT_DATA.
- Frame length from sh_load to the STOP-end tick: (DATA_WIDTH+2)*DIV cycles, plus DIV if parity is enabled.
- in_valid low in WAIT_DATA: line stays IDLE indefinitely. There is no timeout.
- in_valid is only sampled in WAIT_DATA.
- pkt_cnt holds its final value after done until the next accepted start.

Decomposition:
- Shared package parallel_to_serial_params_pkg:
  - existing BAUD_*, PARITY_*, MIN/MAX_NUM_PACKETS.
  - add line_sel_t enum (LINE_IDLE, LINE_START, LINE_DATA, LINE_PARITY, LINE_STOP).
  - add tx_state_t enum (IDLE, WAIT_DATA, START, DATA, PARITY, STOP).
  - add DATA_WIDTH.
- Divisor lookup is a package function baud_div(bit [1:0] sel, int clk_hz).
- One sub-module: piso_baud_gen (divisor counter, restart input, tick output).

Test Plan:
- Reset mid-DATA on 115200: assert rst in bit 3 -> next edge: line_sel=IDLE, busy=0, sh_shift=0, pkt_cnt=0.
- 115200, parity off, num_pkts=1, byte 0xA5:
  - sh_load one cycle after the handshake; 7 sh_shift pulses 434 cycles apart.
  - STOP ends 4340 cycles after sh_load; done pulses; pkt_cnt=1.
- 9600, parity on, byte 0x07 -> parity_bit=1; PARITY state lasts 5208 cycles; frame 57288 cycles.
- num_pkts=3 with in_valid held low 100 cycles between bytes -> line_sel=IDLE during the gaps, pkt_cnt 1,2,3, exactly one done.
- start with cfg_num_pkts=0, then 1001 -> cfg_err pulse each time, busy stays 0, in_ready stays 0.
- start pulsed again mid-burst, and cfg_baud changed mid-burst -> ignored; bit times remain at the latched divisor.
